// File: rtl/adventure_pkg.sv
// Shared types for the direction input block: move directions and input FSM states.
// Button vectors are ordered {W, E, S, N} (bit 0 = N).
package adventure_pkg;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_N,
    DIR_S,
    DIR_E,
    DIR_W
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_FIRE,
    ST_HELD,
    ST_RELEASE
  } in_state_t;

  function automatic logic [3:0] dir_onehot(input dir_t d);
    logic [3:0] v;
    case (d)
      DIR_N:   v = 4'b0001;
      DIR_S:   v = 4'b0010;
      DIR_E:   v = 4'b0100;
      DIR_W:   v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  // Zero or several buttons map to DIR_NONE, so ambiguous chords are never latched.
  function automatic dir_t onehot_dir(input logic [3:0] v);
    dir_t d;
    case (v)
      4'b0001: d = DIR_N;
      4'b0010: d = DIR_S;
      4'b0100: d = DIR_E;
      4'b1000: d = DIR_W;
      default: d = DIR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one raw asynchronous push button.
module btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/direction_input.sv
// Debounced four-way direction input emitting single-cycle move pulses.
// Optional hold-to-repeat is compiled in with the DIR_AUTOREPEAT_EN macro.
module direction_input
  import adventure_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic btn_s,
  input  logic btn_e,
  input  logic btn_w,
  input  logic lock,
  output logic N,
  output logic S,
  output logic E,
  output logic W
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
      REPEAT_CYCLES < 1 || REPEAT_CYCLES > 1048575) begin : g_bad_param
    $error("direction_input: parameter out of range");
  end

  logic [3:0] raw_vec;
  logic [3:0] sync_vec;
  logic       dir_match;
  logic       rep_fire;

  in_state_t  state_q;
  dir_t       dir_q;
  logic [CW-1:0] cnt_q;
  logic [3:0] pulse_q;

  assign raw_vec = {btn_w, btn_e, btn_s, btn_n};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    btn_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (raw_vec[gi]),
      .q_o   (sync_vec[gi])
    );
  end

  assign dir_match = (sync_vec == dir_onehot(dir_q));

`ifdef DIR_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_q <= '0;
    end else if (state_q == ST_HELD && dir_match) begin
      rep_q <= (rep_q == REP_LAST) ? '0 : rep_q + 1'b1;
    end else begin
      rep_q <= '0;
    end
  end

  assign rep_fire = (state_q == ST_HELD) && dir_match && (rep_q == REP_LAST);
`else
  assign rep_fire = 1'b0;
`endif

  // Pulses are registered on the edge that enters FIRE, so they appear during FIRE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_NONE;
      cnt_q   <= '0;
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (onehot_dir(sync_vec) != DIR_NONE) begin
            dir_q   <= onehot_dir(sync_vec);
            cnt_q   <= '0;
            state_q <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (!dir_match) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_FIRE;
            if (!lock) pulse_q <= dir_onehot(dir_q);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_FIRE: begin
          state_q <= ST_HELD;
        end
        ST_HELD: begin
          if (sync_vec == 4'b0000) begin
            cnt_q   <= '0;
            state_q <= ST_RELEASE;
          end else if (rep_fire && !lock) begin
            pulse_q <= dir_onehot(dir_q);
          end
        end
        ST_RELEASE: begin
          if (sync_vec != 4'b0000) begin
            state_q <= ST_HELD;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign N = pulse_q[0];
  assign S = pulse_q[1];
  assign E = pulse_q[2];
  assign W = pulse_q[3];

endmodule

// File: tb/tb_direction_input.sv
// Directed bench for direction_input with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Edge k counts posedges after an input change made between edges.
module tb_direction_input;
  import adventure_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_n = 1'b0, btn_s = 1'b0, btn_e = 1'b0, btn_w = 1'b0;
  logic lock = 1'b0;
  logic N, S, E, W;
  logic [3:0] out_vec;

  int n_cmp = 0;
  int n_bad = 0;

  assign out_vec = {W, E, S, N};

  always #5 clk = ~clk;

  direction_input #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_n),
    .btn_s (btn_s),
    .btn_e (btn_e),
    .btn_w (btn_w),
    .lock  (lock),
    .N     (N),
    .S     (S),
    .E     (E),
    .W     (W)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    btn_n = 1'b0; btn_s = 1'b0; btn_e = 1'b0; btn_w = 1'b0;
    repeat (20) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++;
    if (out_vec !== 4'b0000) begin
      n_bad++; $display("FAIL reset_outputs got=%b want=0000", out_vec);
    end
    n_cmp++;
    if (dut.state_q !== ST_IDLE) begin
      n_bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state_q, ST_IDLE);
    end
    n_cmp++;
    if (dut.dir_q !== DIR_NONE) begin
      n_bad++; $display("FAIL reset_dir got=%0d want=%0d", dut.dir_q, DIR_NONE);
    end
    n_cmp++;
    if (dut.cnt_q !== '0) begin
      n_bad++; $display("FAIL reset_cnt got=%0d want=0", dut.cnt_q);
    end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_latency();
    btn_n = 1'b1;
    for (int k = 1; k <= 207; k++) begin
      step();
      n_cmp++;
      if (out_vec !== ((k == 7) ? 4'b0001 : 4'b0000)) begin
        n_bad++; $display("FAIL latency_n cycle=%0d got=%b want=%b", k, out_vec,
                          (k == 7) ? 4'b0001 : 4'b0000);
      end
    end
    settle();
    $display("test_latency done");
  endtask

  task automatic test_short_press();
    btn_e = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 3) btn_e = 1'b0;
      n_cmp++;
      if (out_vec !== 4'b0000) begin
        n_bad++; $display("FAIL short_press cycle=%0d got=%b want=0000", k, out_vec);
      end
    end
    n_cmp++;
    if (dut.state_q !== ST_IDLE) begin
      n_bad++; $display("FAIL short_press_idle got=%0d want=%0d", dut.state_q, ST_IDLE);
    end
    $display("test_short_press done");
  endtask

  task automatic test_two_buttons();
    btn_n = 1'b1;
    btn_w = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step();
      n_cmp++;
      if (out_vec !== 4'b0000) begin
        n_bad++; $display("FAIL two_buttons cycle=%0d got=%b want=0000", k, out_vec);
      end
    end
    btn_w = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      n_cmp++;
      if (out_vec !== ((k == 7) ? 4'b0001 : 4'b0000)) begin
        n_bad++; $display("FAIL two_then_n cycle=%0d got=%b want=%b", k, out_vec,
                          (k == 7) ? 4'b0001 : 4'b0000);
      end
    end
    settle();
    $display("test_two_buttons done");
  endtask

  task automatic test_lock();
    lock  = 1'b1;
    btn_s = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (k == 20) lock = 1'b0;
      n_cmp++;
      if (out_vec !== 4'b0000) begin
        n_bad++; $display("FAIL lock_suppress cycle=%0d got=%b want=0000", k, out_vec);
      end
    end
    settle();
    btn_s = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      n_cmp++;
      if (out_vec !== ((k == 7) ? 4'b0010 : 4'b0000)) begin
        n_bad++; $display("FAIL lock_repress cycle=%0d got=%b want=%b", k, out_vec,
                          (k == 7) ? 4'b0010 : 4'b0000);
      end
    end
    settle();
    $display("test_lock done");
  endtask

  task automatic test_reset_mid();
    btn_e = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++;
      if (out_vec !== 4'b0000) begin
        n_bad++; $display("FAIL reset_mid_pre cycle=%0d got=%b want=0000", k, out_vec);
      end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (out_vec !== 4'b0000) begin
      n_bad++; $display("FAIL reset_mid_out got=%b want=0000", out_vec);
    end
    n_cmp++;
    if (dut.state_q !== ST_IDLE) begin
      n_bad++; $display("FAIL reset_mid_state got=%0d want=%0d", dut.state_q, ST_IDLE);
    end
    for (int k = 1; k <= 30; k++) begin
      step();
      n_cmp++;
      if (out_vec !== ((k == 7) ? 4'b0100 : 4'b0000)) begin
        n_bad++; $display("FAIL reset_mid_repress cycle=%0d got=%b want=%b", k, out_vec,
                          (k == 7) ? 4'b0100 : 4'b0000);
      end
    end
    settle();
    $display("test_reset_mid done");
  endtask

`ifdef DIR_AUTOREPEAT_EN
  task automatic test_autorepeat();
    logic [3:0] exp_v;
    btn_w = 1'b1;
    for (int k = 1; k <= 47; k++) begin
      step();
      exp_v = ((k == 7) || (k >= 16 && ((k - 16) % 8) == 0)) ? 4'b1000 : 4'b0000;
      n_cmp++;
      if (out_vec !== exp_v) begin
        n_bad++; $display("FAIL autorepeat cycle=%0d got=%b want=%b", k, out_vec, exp_v);
      end
    end
    settle();
    $display("test_autorepeat done");
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_short_press();
    test_two_buttons();
    test_lock();
    test_reset_mid();
`ifdef DIR_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/direction_input.md
DIRECTION_INPUT -- requirements
Module: direction_input

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized cycles required to accept a press or release; legal range 1 to 65535.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 1024, hold-to-repeat interval in cycles; used only with DIR_AUTOREPEAT_EN; legal range 1 to 2^20-1.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports btn_n, btn_s, btn_e, btn_w, input, 1 each, raw asynchronous active-high push buttons.
REQ-006 SHALL have port lock, input, 1; when high, no move pulse is emitted (driven from WIN|DIE downstream).
REQ-007 SHALL have ports N, S, E, W, output, 1 each, registered single-cycle move pulses, at most one high per cycle.

Function
REQ-008 SHALL pass each raw button through a 2-flop synchronizer; only synchronized values drive the FSM.
REQ-009 SHALL implement FSM states IDLE, DEBOUNCE, FIRE, HELD, RELEASE, with a counter cnt sized for DEBOUNCE_CYCLES.
REQ-010 In IDLE: exactly one synchronized button high -> latch it as dir, set cnt=0, go to DEBOUNCE; zero or 2+ high -> stay in IDLE.
REQ-011 In DEBOUNCE: synchronized vector equals one-hot(dir) and cnt==DEBOUNCE_CYCLES-1 -> FIRE; vector equals one-hot(dir) otherwise -> cnt+1; any other vector, including an added second button -> IDLE.
REQ-012 In FIRE: the output matching dir SHALL be high for exactly this one cycle unless lock is high; the next state is always HELD.
REQ-013 In HELD: any synchronized button high -> stay; all low -> set cnt=0 and go to RELEASE.
REQ-014 In RELEASE: all low for DEBOUNCE_CYCLES consecutive cycles -> IDLE; any button high -> HELD.
REQ-015 Latency: with raw input high and stable before clock edge 1, the pulse SHALL be visible in the cycle after edge DEBOUNCE_CYCLES+3, as a single cycle.
REQ-016 A button held indefinitely SHALL produce exactly one pulse without DIR_AUTOREPEAT_EN.
REQ-017 Lock SHALL be sampled in FIRE only; a suppressed press still goes through HELD and RELEASE, so it is never replayed after lock falls.
REQ-018 Outputs N/S/E/W SHALL never show more than one bit high, and never in any state except FIRE (or REPEAT firing, REQ-022).

Reset
REQ-019 Reset SHALL clear synchronizer flops, set state to IDLE, cnt=0, dir=none, and N=S=E=W=0 at the next edge.
REQ-020 Reset asserted mid-operation SHALL abort any pending press without a pulse; a button still held after reset is accepted as a new press once debounced.

Configuration
REQ-021 The macro DIR_AUTOREPEAT_EN SHALL compile in hold-to-repeat; without it the repeat counter and logic are absent.
REQ-022 With DIR_AUTOREPEAT_EN defined: in HELD, while the vector equals one-hot(dir), a repeat counter counts; at REPEAT_CYCLES-1 it emits one pulse on dir (subject to lock) and restarts; any other vector clears it.

Structure
REQ-023 Shared package adventure_pkg SHALL hold the dir_t enum (DIR_NONE, DIR_N, DIR_S, DIR_E, DIR_W) and the input FSM state enum.
REQ-024 The synchronizer SHALL be a sub-module btn_sync (1-bit, 2-flop, synchronous reset), instantiated four times.

Verification
REQ-025 DEBOUNCE_CYCLES=4, btn_n high from edge 1 and held -> N=1 only in the cycle after edge 7, then N=0 for 200 cycles.
REQ-026 btn_e pulsed high for 3 cycles (less than 4) -> no output pulse; FSM returns to IDLE.
REQ-027 btn_n and btn_w asserted on the same edge and held -> no pulse ever; btn_w released -> N pulses once after debounce.
REQ-028 lock=1 during FIRE for btn_s press; lock drops while btn_s is held -> no S pulse; release then new press with lock=0 -> one S pulse.
REQ-029 Reset asserted during DEBOUNCE for btn_e -> no pulse; outputs 0 the cycle after reset.
REQ-030 DIR_AUTOREPEAT_EN, REPEAT_CYCLES=8, btn_w held 40 cycles after first pulse -> W pulses every 8 cycles, one cycle wide.
